// File: rtl/fpmul_pkg.sv
// fpmul_pkg: number format constants, result record and zero-operand helper
// for the shared multiplier scheduler. No ports; imported by fpmul_sched and fpmul_rr_arb.
// Format (24 bits): [23] sign, [22:16] exponent (bias 63), [15:0] fraction (hidden 1).
package fpmul_pkg;

  localparam int FP_W     = 24;
  localparam int EXP_W    = 7;
  localparam int FRAC_W   = 16;
  localparam int EXP_BIAS = 63;

  localparam int SIGN_POS = FP_W - 1;
  localparam int EXP_MSB  = FP_W - 2;
  localparam int EXP_LSB  = FRAC_W;
  localparam int FRAC_MSB = FRAC_W - 1;
  localparam int FRAC_LSB = 0;

  typedef logic [FP_W-1:0] fp_t;

  typedef struct packed {
    fp_t  data;
    logic ovf;
    logic unf;
  } res_t;

  // Exponent and fraction both zero encodes a signed zero.
  function automatic logic fp_is_zero(input fp_t x);
    return (x[EXP_MSB:EXP_LSB] == '0) && (x[FRAC_MSB:FRAC_LSB] == '0);
  endfunction

endpackage

// File: rtl/fpmul_rr_arb.sv
// fpmul_rr_arb: NREQ-wide round-robin arbiter; winner is the first valid index at
// or after the pointer, wrapping. Grant is combinational, pointer updates on accept.
// Backpressure: en=0 suppresses every grant and freezes the pointer.
// Ports: clk, rst (sync, active-high); valid[NREQ], en in; grant[NREQ] one-hot,
//        idx (winner index), accept (any grant) out.
module fpmul_rr_arb import fpmul_pkg::*; #(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          valid,
  input  logic                     en,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  idx,
  output logic                     accept
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] ptr;
  logic           found;

  // Outer loop walks priority order starting at ptr; inner loop maps the
  // rotated position back to a physical index, so no variable bit-select.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && valid[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          found = 1'b1;
          idx   = IDW'(i);
        end
      end
    end
  end

  assign accept = en && found;

  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = accept && (idx == IDW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
    end
  end

endmodule

// File: rtl/fpmul_sched.sv
// fpmul_sched: shares one external pipelined FP multiplier among NREQ requesters,
// tags each issue with its requester id and buffers results in order in a FIFO.
// Latency: accept in cycle t -> dp_valid at t+1 -> res_valid at t+2+LAT.
// Backpressure: credits (fifo_count + inflight < DEPTH) gate grants, so a stalled
//   consumer stops issue instead of overflowing the FIFO; a pop frees credit next cycle.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_a/req_b requester side;
//   dp_valid/dp_a/dp_b issue, dp_res/dp_ovf/dp_unf return (LAT cycles later);
//   res_valid/res_ready/res_data/res_id/res_ovf/res_unf result side; busy status.
// Optional: FPMUL_ZERO_BYPASS_EN forces a signed-zero result (flags clear) when
//   either operand is zero, still occupying its slot in the pipeline.
module fpmul_sched import fpmul_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*FP_W-1:0]     req_a,
  input  logic [NREQ*FP_W-1:0]     req_b,
  output logic                     dp_valid,
  output logic [FP_W-1:0]          dp_a,
  output logic [FP_W-1:0]          dp_b,
  input  logic [FP_W-1:0]          dp_res,
  input  logic                     dp_ovf,
  input  logic                     dp_unf,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [FP_W-1:0]          res_data,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic                     res_ovf,
  output logic                     res_unf,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
`ifdef FPMUL_ZERO_BYPASS_EN
    logic           zero;
    logic           sgn;
`endif
  } tag_t;

  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  inflight;
  logic           credit_ok;
  logic           accept;
  logic           push;
  logic           pop;
  logic [IDW-1:0] gnt_idx;
  fp_t            sel_a;
  fp_t            sel_b;
  tag_t           tag_in;
  tag_t           tag_pipe [LAT+1];
  res_t           cap;
  res_t           mem      [DEPTH];
  logic [IDW-1:0] mem_id   [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Registered counts only: credit freed by a pop becomes usable next cycle.
  // Gating with rst keeps req_ready low while reset is held.
  assign credit_ok = !rst &&
                     (({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(DEPTH));

  fpmul_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .en     (credit_ok),
    .grant  (req_ready),
    .idx    (gnt_idx),
    .accept (accept)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[i*FP_W +: FP_W];
        sel_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_comb begin
    tag_in     = '0;
    tag_in.vld = accept;
    tag_in.id  = gnt_idx;
`ifdef FPMUL_ZERO_BYPASS_EN
    tag_in.zero = fp_is_zero(sel_a) || fp_is_zero(sel_b);
    tag_in.sgn  = sel_a[SIGN_POS] ^ sel_b[SIGN_POS];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_a     <= '0;
      dp_b     <= '0;
    end else begin
      dp_valid <= accept;
      if (accept) begin
        dp_a <= sel_a;
        dp_b <= sel_b;
      end
    end
  end

  // Stage 0 rides alongside dp_valid; stage LAT lines up with dp_res.
  // Clearing the chain on reset is what discards results still in the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j <= LAT; j++) tag_pipe[j] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int j = 1; j <= LAT; j++) tag_pipe[j] <= tag_pipe[j-1];
    end
  end

  assign push = tag_pipe[LAT].vld;
  assign pop  = res_valid && res_ready;

  always_comb begin
    cap.data = dp_res;
    cap.ovf  = dp_ovf;
    cap.unf  = dp_unf;
`ifdef FPMUL_ZERO_BYPASS_EN
    if (tag_pipe[LAT].zero) begin
      cap.data = {tag_pipe[LAT].sgn, {(FP_W-1){1'b0}}};
      cap.ovf  = 1'b0;
      cap.unf  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]    <= cap;
      mem_id[wr_ptr] <= tag_pipe[LAT].id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      inflight   <= inflight + CW'(accept) - CW'(push);
    end
  end

  // Outputs read zero when empty so the reset/idle state is clean; while
  // valid they come straight from the head entry and hold until popped.
  assign res_valid = (fifo_count != '0);
  assign res_data  = res_valid ? mem[rd_ptr].data : '0;
  assign res_ovf   = res_valid ? mem[rd_ptr].ovf  : 1'b0;
  assign res_unf   = res_valid ? mem[rd_ptr].unf  : 1'b0;
  assign res_id    = res_valid ? mem_id[rd_ptr]   : '0;
  assign busy      = (inflight != '0) || (fifo_count != '0);

  assert property (@(posedge clk) disable iff (rst) !(push && (fifo_count == CW'(DEPTH))))
    else $error("result push into full FIFO");

endmodule

// File: tb/tb_fpmul_sched.sv
module tb_fpmul_sched;

  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*24-1:0] req_a = '0;
  logic [NREQ*24-1:0] req_b = '0;
  logic              dp_valid;
  logic [23:0]       dp_a, dp_b, dp_res;
  logic              dp_ovf, dp_unf;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [23:0]       res_data;
  logic [1:0]        res_id;
  logic              res_ovf, res_unf, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpmul_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b),
    .dp_res(dp_res), .dp_ovf(dp_ovf), .dp_unf(dp_unf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_ovf(res_ovf), .res_unf(res_unf), .busy(busy)
  );

  // Reference multiplier: {ovf, unf, result}. Truncating, saturates on overflow,
  // flushes to signed zero on underflow.
  function automatic logic [25:0] fmul(input logic [23:0] a, input logic [23:0] b);
    logic        s;
    int          e;
    logic [33:0] ma, mb, m;
    logic [15:0] f;
    s  = a[23] ^ b[23];
    e  = int'(a[22:16]) + int'(b[22:16]) - 63;
    ma = {17'b0, 1'b1, a[15:0]};
    mb = {17'b0, 1'b1, b[15:0]};
    m  = ma * mb;
    if (m[33]) begin
      f = m[32:17];
      e = e + 1;
    end else begin
      f = m[31:16];
    end
    if (e > 127) return {2'b10, s, 7'h7F, 16'hFFFF};
    if (e < 1)   return {2'b01, s, 23'b0};
    return {2'b00, s, e[6:0], f};
  endfunction

  logic [25:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= fmul(dp_a, dp_b);
    for (int j = 1; j < LAT; j++) dp_pipe[j] <= dp_pipe[j-1];
  end
  assign dp_res = dp_pipe[LAT-1][23:0];
  assign dp_unf = dp_pipe[LAT-1][24];
  assign dp_ovf = dp_pipe[LAT-1][25];

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    smp();
    checks++;
    if (req_ready !== 4'b0000 || dp_valid !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy=%b dpv=%b rv=%b busy=%b want 0000 0 0 0",
               req_ready, dp_valid, res_valid, busy);
    end
    checks++;
    if (dp_a !== 24'h0 || dp_b !== 24'h0 || res_data !== 24'h0 || res_id !== 2'd0 ||
        res_ovf !== 1'b0 || res_unf !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: got dp_a=%h dp_b=%h data=%h id=%0d ovf=%b unf=%b want all 0",
               dp_a, dp_b, res_data, res_id, res_ovf, res_unf);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_a[23:0] = 24'h3F8000;
    req_b[23:0] = 24'h400000;
    req_valid   = 4'b0001;
    smp();
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    nxt();
    req_valid = '0;
    smp();
    checks++;
    if (dp_valid !== 1'b1 || dp_a !== 24'h3F8000 || dp_b !== 24'h400000) begin
      failures++;
      $display("FAIL single_issue: got v=%b a=%h b=%h want 1 3f8000 400000", dp_valid, dp_a, dp_b);
    end
    for (int k = 2; k <= 4; k++) begin
      nxt();
      smp();
      checks++;
      if (res_valid !== (k == 4)) begin
        failures++;
        $display("FAIL single_latency: cycle t+%0d got res_valid=%b want %b", k, res_valid, (k == 4));
      end
    end
    checks++;
    if (res_data !== 24'h408000 || res_id !== 2'd0 || res_ovf !== 1'b0 || res_unf !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_result: got data=%h id=%0d ovf=%b unf=%b busy=%b want 408000 0 0 0 1",
               res_data, res_id, res_ovf, res_unf, busy);
    end
    res_ready = 1'b1;
    nxt();
    res_ready = 1'b0;
    smp();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: got rv=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  // An op holds its credit from t+1 through its pop at t+4, so with DEPTH=4 the
  // issue cadence is four accepts then one credit bubble.
  task automatic test_round_robin();
    logic [3:0]  g   [10];
    logic [23:0] ed  [8];
    logic [1:0]  eid [8];
    int got;
    g   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
            4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    ed  = '{24'h400000, 24'h402000, 24'h404000, 24'h406000,
            24'h400000, 24'h402000, 24'h404000, 24'h406000};
    eid = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*24 +: 24] = {1'b0, 7'd63, 16'(i * 16'h2000)};
      req_b[i*24 +: 24] = 24'h400000;
    end
    res_ready = 1'b1;
    req_valid = 4'b1111;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      smp();
      checks++;
      if (req_ready !== g[c]) begin
        failures++;
        $display("FAIL rr_grant: cycle %0d got %b want %b", c, req_ready, g[c]);
      end
      if (res_valid === 1'b1) begin
        checks++;
        if (got >= 8 || res_data !== ed[got] || res_id !== eid[got]) begin
          failures++;
          $display("FAIL rr_result: idx %0d got data=%h id=%0d", got, res_data, res_id);
        end
        got++;
      end
      nxt();
    end
    req_valid = '0;
    for (int c = 0; c < 20 && got < 8; c++) begin
      smp();
      if (res_valid === 1'b1) begin
        checks++;
        if (res_data !== ed[got] || res_id !== eid[got]) begin
          failures++;
          $display("FAIL rr_result: idx %0d got data=%h id=%0d want %h %0d",
                   got, res_data, res_id, ed[got], eid[got]);
        end
        got++;
      end
      nxt();
    end
    checks++;
    if (got != 8) begin
      failures++;
      $display("FAIL rr_count: got %0d results want 8", got);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc;
    int k;
    int got;
    logic [23:0] ed [5];
    ed = '{24'h400000, 24'h401000, 24'h402000, 24'h403000, 24'h404000};
    do_reset();
    k = 0;
    acc = 0;
    req_a[47:24] = 24'h3F0000;
    req_b[47:24] = 24'h400000;
    req_valid = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      smp();
      if (req_ready[1] === 1'b1) begin
        acc++;
        k++;
      end
      nxt();
      req_a[47:24] = {1'b0, 7'd63, 16'(k * 16'h1000)};
    end
    checks++;
    if (acc != DEPTH) begin
      failures++;
      $display("FAIL bp_accepts: got %0d want %0d", acc, DEPTH);
    end
    smp();
    checks++;
    if (req_ready !== 4'b0000 || res_valid !== 1'b1 || res_data !== 24'h400000 || res_id !== 2'd1) begin
      failures++;
      $display("FAIL bp_hold: got rdy=%b rv=%b data=%h id=%0d want 0000 1 400000 1",
               req_ready, res_valid, res_data, res_id);
    end
    nxt();
    res_ready = 1'b1;
    smp();
    checks++;
    if (req_ready !== 4'b0000 || res_data !== 24'h400000) begin
      failures++;
      $display("FAIL bp_pop_cycle: got rdy=%b data=%h want 0000 400000", req_ready, res_data);
    end
    nxt();
    smp();
    checks++;
    if (req_ready !== 4'b0010 || res_data !== 24'h401000) begin
      failures++;
      $display("FAIL bp_resume: got rdy=%b data=%h want 0010 401000", req_ready, res_data);
    end
    nxt();
    req_valid = '0;
    got = 2;
    for (int c = 0; c < 20 && got < 5; c++) begin
      smp();
      if (res_valid === 1'b1) begin
        checks++;
        if (res_data !== ed[got] || res_id !== 2'd1) begin
          failures++;
          $display("FAIL bp_order: idx %0d got %h id=%0d want %h 1", got, res_data, res_id, ed[got]);
        end
        got++;
      end
      nxt();
    end
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL bp_count: got %0d results want 5", got);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_flags();
    logic [23:0] op   [2];
    logic [23:0] ed   [2];
    logic [1:0]  eid  [2];
    logic        eovf [2];
    logic        eunf [2];
    logic        seen;
    op   = '{24'h7F8000, 24'h010000};
    ed   = '{24'h7FFFFF, 24'h000000};
    eid  = '{2'd2, 2'd3};
    eovf = '{1'b1, 1'b0};
    eunf = '{1'b0, 1'b1};
    do_reset();
    res_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      req_a[int'(eid[v])*24 +: 24] = op[v];
      req_b[int'(eid[v])*24 +: 24] = op[v];
      req_valid = 4'b0001 << eid[v];
      nxt();
      req_valid = '0;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        smp();
        if (res_valid === 1'b1) seen = 1'b1;
        else nxt();
      end
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL flags_timeout: vector %0d got no res_valid want 1", v);
      end else if (res_ovf !== eovf[v] || res_unf !== eunf[v] || res_id !== eid[v] || res_data !== ed[v]) begin
        failures++;
        $display("FAIL flags_result: vector %0d got ovf=%b unf=%b id=%0d data=%h want %b %b %0d %h",
                 v, res_ovf, res_unf, res_id, res_data, eovf[v], eunf[v], eid[v], ed[v]);
      end
      nxt();
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      smp();
      checks++;
      if (req_ready !== (4'b0001 << c)) begin
        failures++;
        $display("FAIL rstmid_grant: cycle %0d got %b want %b", c, req_ready, 4'b0001 << c);
      end
      nxt();
    end
    req_valid = '0;
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    smp();
    checks++;
    if (req_ready !== 4'b0 || dp_valid !== 1'b0 || dp_a !== 24'h0 || dp_b !== 24'h0 ||
        res_valid !== 1'b0 || res_data !== 24'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs: got rdy=%b dpv=%b dp_a=%h rv=%b data=%h busy=%b want all 0",
               req_ready, dp_valid, dp_a, res_valid, res_data, busy);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      nxt();
      smp();
      if (res_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rstmid_stale: got %0d res_valid cycles want 0", seen);
    end
    nxt();
    req_valid = 4'b1111;
    smp();
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_ptr: got %b want 0001", req_ready);
    end
    nxt();
    req_valid = '0;
    res_ready = 1'b1;
    for (int c = 0; c < 8; c++) nxt();
    res_ready = 1'b0;
  endtask

  task automatic test_zero();
    logic eunf;
`ifdef FPMUL_ZERO_BYPASS_EN
    eunf = 1'b0;
`else
    eunf = 1'b1;
`endif
    do_reset();
    res_ready = 1'b1;
    req_a[23:0] = 24'h800000;
    req_b[23:0] = 24'h3F8000;
    req_valid = 4'b0001;
    nxt();
    req_valid = '0;
    nxt();
    nxt();
    nxt();
    smp();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 24'h800000 || res_ovf !== 1'b0 || res_unf !== eunf || res_id !== 2'd0) begin
      failures++;
      $display("FAIL zero_op: got rv=%b data=%h ovf=%b unf=%b id=%0d want 1 800000 0 %b 0",
               res_valid, res_data, res_ovf, res_unf, res_id, eunf);
    end
    nxt();
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flags();
    test_reset_mid();
    test_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 want finish");
    $fatal(1, "watchdog");
  end

endmodule
